// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding control.
package mips_pipe_pkg;

  // Scoreboard register fields are stored at this width; narrower addresses are zero-extended.
  localparam int SB_REG_W    = 8;
  localparam int FWD_REGFILE = 0;
  localparam int SLOT_EX     = 0;
  localparam int SLOT_MEM    = 1;
  localparam int SLOT_WB     = 2;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
    logic [SB_REG_W-1:0] rs;
    logic [SB_REG_W-1:0] rt;
    logic                uses_rs;
    logic                uses_rt;
  } sb_entry_t;

  // Register $0 is hardwired, so it never produces a dependency.
  function automatic logic sb_match(sb_entry_t e, logic [SB_REG_W-1:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle between the pipe and the hazard unit.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_SEL_W  = 2,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  ex_redirect;
  logic                  mem_busy;
  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [FWD_SEL_W-1:0]  fwd_a_sel;
  logic [FWD_SEL_W-1:0]  fwd_b_sel;
  logic                  load_use_stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite,
           id_memread, ex_redirect, mem_busy,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, load_use_stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite,
           id_memread, ex_redirect, mem_busy,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, load_use_stall, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard (slot 0 = EX) with load-use and forward-select match logic.
module hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int FWD_SEL_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  sb_entry_t            new_entry,
  input  logic                 id_valid,
  input  logic [SB_REG_W-1:0]  id_rs,
  input  logic [SB_REG_W-1:0]  id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  output logic                 load_hit,
  output logic [FWD_SEL_W-1:0] fwd_a_sel,
  output logic [FWD_SEL_W-1:0] fwd_b_sel
);

  sb_entry_t slot [DEPTH+1];

  // Only the valid bits are control; payload fields are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) slot[k].valid <= 1'b0;
    end else if (advance) begin
      slot[0] <= new_entry;
      for (int k = 1; k <= DEPTH; k++) slot[k] <= slot[k-1];
    end
  end

  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < LOAD_LATENCY; k++) begin
      if (id_valid && slot[k].is_load &&
          ((id_uses_rs && sb_match(slot[k], id_rs)) ||
           (id_uses_rt && sb_match(slot[k], id_rt))))
        load_hit = 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    fwd_a_sel = FWD_SEL_W'(FWD_REGFILE);
    fwd_b_sel = FWD_SEL_W'(FWD_REGFILE);
    for (int k = DEPTH; k >= 1; k--) begin
      if (slot[SLOT_EX].valid && slot[SLOT_EX].uses_rs && sb_match(slot[k], slot[SLOT_EX].rs))
        fwd_a_sel = FWD_SEL_W'(k);
      if (slot[SLOT_EX].valid && slot[SLOT_EX].uses_rt && sb_match(slot[k], slot[SLOT_EX].rt))
        fwd_b_sel = FWD_SEL_W'(k);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: stall, flush and freeze priority decode around the scoreboard.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int FWD_SEL_W      = $clog2(NUM_FWD_STAGES + 1),
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  logic                 load_hit;
  logic                 stall;
  logic                 advance;
  logic [FWD_SEL_W-1:0] fwd_a;
  logic [FWD_SEL_W-1:0] fwd_b;
  logic [CNT_W-1:0]     stall_cnt;
  sb_entry_t            new_entry;

  // Freeze beats redirect, and redirect beats load-use stall.
  assign advance = !hz.mem_busy;
  assign stall   = !reset && !hz.mem_busy && !hz.ex_redirect && load_hit;

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = hz.id_valid && !stall && !hz.ex_redirect;
    new_entry.rd       = SB_REG_W'(hz.id_rd);
    new_entry.regwrite = hz.id_regwrite;
    new_entry.is_load  = hz.id_memread;
    new_entry.rs       = SB_REG_W'(hz.id_rs);
    new_entry.rt       = SB_REG_W'(hz.id_rt);
    new_entry.uses_rs  = hz.id_uses_rs;
    new_entry.uses_rt  = hz.id_uses_rt;
  end

  hazard_scoreboard #(
    .DEPTH        (NUM_FWD_STAGES),
    .LOAD_LATENCY (LOAD_LATENCY),
    .FWD_SEL_W    (FWD_SEL_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .new_entry  (new_entry),
    .id_valid   (hz.id_valid),
    .id_rs      (SB_REG_W'(hz.id_rs)),
    .id_rt      (SB_REG_W'(hz.id_rt)),
    .id_uses_rs (hz.id_uses_rs),
    .id_uses_rt (hz.id_uses_rt),
    .load_hit   (load_hit),
    .fwd_a_sel  (fwd_a),
    .fwd_b_sel  (fwd_b)
  );

  always_comb begin
    hz.pc_write_en    = 1'b1;
    hz.if_id_write_en = 1'b1;
    hz.if_id_flush    = 1'b0;
    hz.id_ex_bubble   = 1'b0;
    hz.load_use_stall = 1'b0;
    hz.fwd_a_sel      = reset ? FWD_SEL_W'(FWD_REGFILE) : fwd_a;
    hz.fwd_b_sel      = reset ? FWD_SEL_W'(FWD_REGFILE) : fwd_b;
    if (!reset) begin
      if (hz.mem_busy) begin
        hz.pc_write_en    = 1'b0;
        hz.if_id_write_en = 1'b0;
      end else begin
        hz.if_id_flush    = hz.ex_redirect;
        hz.id_ex_bubble   = hz.ex_redirect || stall;
        hz.pc_write_en    = !stall;
        hz.if_id_write_en = !stall;
        hz.load_use_stall = stall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign hz.stall_count = stall_cnt;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS core; sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Tracks in-flight destination registers in an internal scoreboard shift register.
- Generates the PC/IF-ID write enables, the flush/bubble controls and the EX-operand forward selects.
- Generalises the classic 5-stage unit: configurable forward depth, load-use latency, plus a memory-freeze input and a saturating stall counter.

Parameters:
- REG_ADDR_W, 5: register-address width.
- NUM_FWD_STAGES, 2: number of post-EX slots that can forward (1 = EX/MEM, 2 = MEM/WB, ...).
- LOAD_LATENCY, 1: cycles after EX before load data is forwardable; range 0..NUM_FWD_STAGES-1.
- FWD_SEL_W, $clog2(NUM_FWD_STAGES+1): width of the forward-select outputs.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  ID source register A.
- id_rt  in  REG_ADDR_W  ID source register B.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_ADDR_W  ID destination (after RegDst/jal mux).
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memread  in  1  ID instruction is a load.
- ex_redirect  in  1  taken branch/jump/jr resolved this cycle.
- mem_busy  in  1  data memory not ready; freeze whole pipe.
- pc_write_en  out  1  PC may update.
- if_id_write_en  out  1  IF/ID may load.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_bubble  out  1  ID/EX loads NOP (control zeroed).
- fwd_a_sel  out  FWD_SEL_W  EX operand A source: 0 = regfile, k = slot k.
- fwd_b_sel  out  FWD_SEL_W  EX operand B source, same encoding.
- load_use_stall  out  1  stall caused by load-use this cycle.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Scoreboard has slots 0..NUM_FWD_STAGES; slot 0 is EX. Each entry holds {valid, rd, regwrite, is_load, rs, rt, uses_rs, uses_rt}; rs/rt/uses are needed only for slot 0.
- Advance (no mem_busy): slot k+1 <= slot k; slot 0 <= ID fields if id_valid & !stall & !ex_redirect, else an invalid bubble.
- Match(slot k, r) = valid & regwrite & rd==r & r!=0. Register $0 never matches.
- Load-use stall: ID source used & Match(slot k) & is_load for some k < LOAD_LATENCY. With LOAD_LATENCY=0 it never stalls. Evaluated combinationally from registered state and ID inputs.
- On stall: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, load_use_stall=1.
- Forward select: lowest k in 1..NUM_FWD_STAGES with Match(slot k, slot0.rs) & slot0.uses_rs drives fwd_a_sel (youngest wins); same rule for fwd_b_sel with rt. Output is 0 if there is no match or slot 0 is invalid.
- ex_redirect: if_id_flush=1, id_ex_bubble=1, slot 0 receives a bubble next cycle. The slot currently in EX (the branch itself) advances normally. Redirect overrides stall: load_use_stall=0, pc_write_en=1.
- mem_busy: all slots hold; pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=0, load_use_stall=0, stall_count holds. Forward selects stay valid for the held state. mem_busy has priority over ex_redirect; the redirect must be re-presented by the caller while the branch remains in EX.
- stall_count increments on each cycle with load_use_stall=1 and saturates at all-ones.
- Reset, including mid-operation: all slots invalid, stall_count=0, pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0, fwd_*_sel=0, load_use_stall=0.

Decomposition:
- Shared package mips_pipe_pkg: scoreboard entry struct, FWD_REGFILE=0 constant, slot-index constants (SLOT_EX=0, SLOT_MEM=1, SLOT_WB=2).
- One sub-module: hazard_scoreboard (shift register plus match logic, parametrised depth). Top level adds priority/stall/flush decode and the counter.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> fwd_a_sel=1 in the sub's EX cycle; no stall.
- lw $3 then add $6,$3,$3 (LOAD_LATENCY=1) -> exactly 1 cycle load_use_stall=1, id_ex_bubble=1, then fwd_a_sel=fwd_b_sel=2; stall_count=1.
- addi $0,$0,5 then add $7,$0,$0 -> fwd selects 0, no stall.
- Load-use hazard with ex_redirect in the same cycle -> load_use_stall=0, if_id_flush=1, pc_write_en=1; the next EX slot is a bubble.
- mem_busy high 3 cycles during a forwarded pair -> write enables 0, fwd_a_sel held at 1 for all 3 cycles, scoreboard unchanged.
- Reset asserted mid-stall with NUM_FWD_STAGES=3, LOAD_LATENCY=2 -> next cycle all outputs at reset values, stall_count=0; a load-use after reset stalls 2 cycles.
